qei_gen: RTL and testbench

Quadrature encoder signal generator: the transmit-side counterpart of the qei decoder. It drives a 2-bit A/B quadrature pair that steps a tracked position toward a commanded target at a programmable step rate. It is used as an encoder emulator for motor-less bring-up and for closed-loop self-test: qei_gen.qei_quad is wired to qei.qei_quad, and qei.qei_position must track qei_gen.position.

---
 rtl/qei_gen.sv | 109 ++++++++++
 tb/tb_qei_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qei_gen.sv
// rtl/qei_gen.sv - quadrature encoder emulator stepping position toward a commanded target
// Emits a gray-coded {B,A} pair, one edge per step, at a programmable step period.
module qei_gen #(
   parameter int WIDTH     = 32,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 cmd_valid,
   input  logic [WIDTH-1:0]     cmd_target,
   input  logic                 load,
   input  logic [WIDTH-1:0]     preset,
   input  logic [DIV_WIDTH-1:0] period,
   output logic [1:0]           qei_quad,
   output logic [WIDTH-1:0]     position,
   output logic                 busy,
   output logic                 done
);

   localparam logic [WIDTH-1:0]     POS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]           quad_q, quad_d;
   logic [WIDTH-1:0]     pos_q, pos_d;
   logic [WIDTH-1:0]     tgt_q, tgt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     diff;
   logic [DIV_WIDTH-1:0] p_last;
   logic                 moving;
   logic                 step_due;
   logic                 dir_up;
   logic [1:0]           quad_fwd;
   logic [1:0]           quad_rev;

   // Modulo difference: MSB clear means the shorter way round is upward.
   assign diff     = tgt_q - pos_q;
   assign moving   = enable && (diff != '0);
   assign dir_up   = ~diff[WIDTH-1];
   assign p_last   = (period == '0) ? '0 : (period - DIV_ONE);
   assign step_due = moving && (div_q >= p_last);

   always_comb begin
      quad_fwd = 2'b00;
      quad_rev = 2'b00;
      case (quad_q)
         2'b00: begin quad_fwd = 2'b01; quad_rev = 2'b10; end
         2'b01: begin quad_fwd = 2'b11; quad_rev = 2'b00; end
         2'b11: begin quad_fwd = 2'b10; quad_rev = 2'b01; end
         default: begin quad_fwd = 2'b00; quad_rev = 2'b11; end
      endcase
   end

   always_comb begin
      quad_d = quad_q;
      pos_d  = pos_q;
      tgt_d  = tgt_q;
      div_d  = div_q;
      done_d = 1'b0;
      if (load) begin
         pos_d = preset;
         tgt_d = preset;
         div_d = '0;
      end else if (cmd_valid) begin
         // Keep the divider phase so a mid-move retarget does not stretch the step.
         tgt_d = cmd_target;
         if (!enable) begin
            div_d = '0;
         end
      end else if (!moving) begin
         div_d = '0;
      end else if (step_due) begin
         quad_d = dir_up ? quad_fwd : quad_rev;
         pos_d  = dir_up ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
         div_d  = '0;
         done_d = (pos_d == tgt_q);
      end else begin
         div_d = div_q + DIV_ONE;
      end
      busy_d = enable && (pos_d != tgt_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         quad_q <= 2'b00;
         pos_q  <= '0;
         tgt_q  <= '0;
         div_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quad_q <= quad_d;
         pos_q  <= pos_d;
         tgt_q  <= tgt_d;
         div_q  <= div_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign qei_quad = quad_q;
   assign position = pos_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_qei_gen.sv
// tb/tb_qei_gen.sv - scoreboard bench for qei_gen with directed and random stimulus
// A behavioural model predicts every cycle's outputs; a monitor pops and compares.
module tb_qei_gen;

   localparam int W  = 32;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic          cmd_valid;
   logic [W-1:0]  cmd_target;
   logic          load;
   logic [W-1:0]  preset;
   logic [DW-1:0] period;
   logic [1:0]    qei_quad;
   logic [W-1:0]  position;
   logic          busy;
   logic          done;

   qei_gen #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
      .cmd_target(cmd_target), .load(load), .preset(preset), .period(period),
      .qei_quad(qei_quad), .position(position), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic         rst;
      logic [1:0]   quad;
      logic [W-1:0] pos;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Reference model: position walks one unit toward target every p_eff clocks.
   logic [W-1:0] m_pos = '0;
   logic [W-1:0] m_tgt = '0;
   int           m_idx = 0;
   int           m_elapsed = 0;
   logic [1:0]   gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   initial begin
      exp_t e;
      logic m_done;
      int   pe;
      logic signed [W-1:0] sdiff;
      forever begin
         @(posedge clock);
         m_done = 1'b0;
         if (reset) begin
            m_pos = '0; m_tgt = '0; m_idx = 0; m_elapsed = 0;
         end else if (load) begin
            m_pos = preset; m_tgt = preset; m_elapsed = 0;
         end else if (cmd_valid) begin
            m_tgt = cmd_target;
            if (!enable) m_elapsed = 0;
         end else if (!enable || m_pos == m_tgt) begin
            m_elapsed = 0;
         end else begin
            pe = (period == 0) ? 1 : int'(period);
            if (m_elapsed + 1 >= pe) begin
               sdiff = $signed(m_tgt - m_pos);
               if (sdiff > 0) begin
                  m_pos = m_pos + 1; m_idx = (m_idx + 1) % 4;
               end else begin
                  m_pos = m_pos - 1; m_idx = (m_idx + 3) % 4;
               end
               m_elapsed = 0;
               m_done = (m_pos == m_tgt);
            end else begin
               m_elapsed = m_elapsed + 1;
            end
         end
         e.rst  = reset;
         e.quad = gray_tab[m_idx];
         e.pos  = m_pos;
         e.busy = enable && !reset && (m_pos != m_tgt);
         e.done = m_done;
         sb.push_back(e);
      end
   end

   logic [1:0] prev_quad = 2'b00;
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("quad", 64'(qei_quad), 64'(e.quad));
            check("position", 64'(position), 64'(e.pos));
            check("busy", 64'(busy), 64'(e.busy));
            check("done", 64'(done), 64'(e.done));
            if (!e.rst) check("single_bit_change", 64'($countones(qei_quad ^ prev_quad) <= 1), 64'd1);
            prev_quad = qei_quad;
         end
      end
   end

   task automatic drive(input logic r, input logic en, input logic cv, input logic [W-1:0] ct,
                        input logic ld, input logic [W-1:0] pr, input logic [DW-1:0] per);
      @(negedge clock);
      reset = r; enable = en; cmd_valid = cv; cmd_target = ct;
      load = ld; preset = pr; period = per;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, enable, 1'b0, cmd_target, 1'b0, preset, period);
   endtask

   task automatic cmd(input logic [W-1:0] t);
      drive(1'b0, enable, 1'b1, t, 1'b0, preset, period);
   endtask

   task automatic do_load(input logic [W-1:0] p);
      drive(1'b0, enable, 1'b0, cmd_target, 1'b1, p, period);
   endtask

   task automatic set_period(input logic [DW-1:0] p);
      drive(1'b0, enable, 1'b0, cmd_target, 1'b0, preset, p);
   endtask

   task automatic set_enable(input logic en);
      drive(1'b0, en, 1'b0, cmd_target, 1'b0, preset, period);
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max; i++) begin
         idle(1);
         if (!busy) return;
      end
      tests++;
      fails++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", max);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_target = '0;
      load = 1'b0; preset = '0; period = 16'd2;

      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 16'd2);
      drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 16'd2);
      set_enable(1'b1);
      idle(3);
      check("idle_position", 64'(position), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);

      cmd(32'd4);
      wait_idle(40);
      check("fwd_position", 64'(position), 64'd4);
      check("fwd_quad", 64'(qei_quad), 64'd0);

      cmd(32'd0);
      idle(4);
      cmd(32'd5);
      wait_idle(40);
      check("reversal_position", 64'(position), 64'd5);

      set_period(16'd1);
      do_load(32'hFFFF_FFFE);
      cmd(32'h0000_0001);
      wait_idle(20);
      check("wrap_position", 64'(position), 64'd1);
      cmd(32'h8000_0001);
      idle(3);
      check("half_range_dec", 64'(position), 64'hFFFF_FFFF);
      do_load(32'd100);

      set_period(16'd0);
      cmd(32'd110);
      wait_idle(40);
      check("period0_position", 64'(position), 64'd110);

      set_period(16'd8);
      cmd(32'd200);
      idle(5);
      set_period(16'd1);
      wait_idle(400);

      set_period(16'd2);
      cmd(32'd300);
      idle(5);
      set_enable(1'b0);
      idle(4);
      check("disabled_busy", 64'(busy), 64'd0);
      set_enable(1'b1);
      idle(5);
      set_period(16'd1);
      do_load(32'd1000);
      idle(1);
      check("load_position", 64'(position), 64'd1000);
      cmd(32'd1003);
      idle(2);
      drive(1'b1, 1'b1, 1'b0, cmd_target, 1'b0, preset, period);
      drive(1'b0, 1'b1, 1'b0, cmd_target, 1'b0, preset, period);
      check("reset_position", 64'(position), 64'd0);
      check("reset_quad", 64'(qei_quad), 64'd0);

      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         logic [W-1:0] t;
         logic en;
         logic [DW-1:0] per;
         r   = $urandom_range(0, 99);
         en  = ($urandom_range(0, 9) != 0);
         per = (r < 25) ? 16'($urandom_range(0, 3)) : period;
         if (r < 2) begin
            drive(1'b1, en, 1'b0, cmd_target, 1'b0, preset, per);
         end else if (r < 5) begin
            t = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            drive(1'b0, en, 1'b0, cmd_target, 1'b1, t, per);
         end else if (r < 15) begin
            if ($urandom_range(0, 9) == 0) t = m_pos + 32'h8000_0000;
            else t = m_pos + 32'($urandom_range(0, 12)) - 32'd6;
            drive(1'b0, en, 1'b1, t, 1'b0, preset, per);
         end else begin
            drive(1'b0, en, 1'b0, cmd_target, 1'b0, preset, per);
         end
      end

      idle(3);
      @(negedge clock);
      check("scoreboard_drained", 64'(sb.size() <= 1), 64'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
